// File: rtl/flight_sequencer.sv
// rtl/flight_sequencer.sv - flight command sequencer driving axis velocity/position selects.
// Optional abort input during warp arming is enabled by FLIGHT_SEQ_WARP_ABORT_EN.
module flight_sequencer #(
  parameter int ARM_CYCLES      = 4,
  parameter int COOLDOWN_CYCLES = 8,
  parameter int CNT_W           = 4
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef FLIGHT_SEQ_WARP_ABORT_EN
  input  logic       abort,
`endif
  input  logic       cmd_valid,
  input  logic [2:0] cmd_op,
  output logic       cmd_ready,
  output logic [3:0] mode_sel,
  output logic [3:0] pos_sel,
  output logic       busy,
  output logic [2:0] state_o,
  output logic       cmd_err,
  output logic [7:0] warp_count
);

  typedef enum logic [2:0] {
    S_ZERO   = 3'd0,
    S_IDLE   = 3'd1,
    S_CRUISE = 3'd2,
    S_ARM    = 3'd3,
    S_WARP   = 3'd4,
    S_COOL   = 3'd5
  } state_t;

  localparam logic [3:0] MODE_ZERO = 4'b0001;
  localparam logic [3:0] POS_CLEAR = 4'b0001;
  localparam logic [3:0] POS_ACC   = 4'b0010;
  localparam logic [3:0] POS_WARP  = 4'b0100;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       pend, pend_n, pend_eff;
  logic [3:0]       mode_n, pos_n, op_mode;
  logic [7:0]       wc_n;
  logic             err_n, ready_n, busy_n, accept, abort_req;

`ifdef FLIGHT_SEQ_WARP_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign accept  = cmd_valid && cmd_ready;
  assign state_o = state;

  // Mode opcodes decode to their one-hot velocity select; zero means "not a mode op".
  always_comb begin
    op_mode = 4'b0000;
    case (cmd_op)
      3'd2:    op_mode = 4'b0010;
      3'd3:    op_mode = 4'b0100;
      3'd4:    op_mode = 4'b1000;
      default: op_mode = 4'b0000;
    endcase
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    mode_n   = mode_sel;
    pend_n   = pend;
    pend_eff = pend;
    wc_n     = warp_count;
    err_n    = 1'b0;
    case (state)
      S_ZERO: state_n = S_IDLE;
      S_IDLE, S_CRUISE: begin
        if (accept) begin
          if (op_mode != 4'b0000) begin
            state_n = S_CRUISE;
            mode_n  = op_mode;
          end else begin
            case (cmd_op)
              3'd1:    state_n = S_IDLE;
              3'd5: begin
                state_n = S_ARM;
                cnt_n   = CNT_W'(ARM_CYCLES - 1);
              end
              3'd6:    state_n = S_ZERO;
              3'd7:    err_n   = 1'b1;
              default: state_n = state;
            endcase
          end
        end
      end
      S_ARM: begin
        if (abort_req) begin
          state_n = S_IDLE;
          err_n   = 1'b1;
        end else if (cnt == '0) begin
          state_n = S_WARP;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_WARP: begin
        state_n = S_COOL;
        cnt_n   = CNT_W'(COOLDOWN_CYCLES - 1);
        pend_n  = 4'b0000;
        if (warp_count != 8'hFF) wc_n = warp_count + 8'd1;
      end
      S_COOL: begin
        // The accepted command is folded in before the exit decision on the last cycle.
        if (accept) begin
          if (op_mode != 4'b0000) pend_eff = op_mode;
          else if (cmd_op == 3'd1) pend_eff = 4'b0000;
          else if (cmd_op == 3'd5 || cmd_op == 3'd7) err_n = 1'b1;
        end
        pend_n = pend_eff;
        if (accept && cmd_op == 3'd6) begin
          state_n = S_ZERO;
        end else if (cnt == '0) begin
          pend_n = 4'b0000;
          if (pend_eff != 4'b0000) begin
            state_n = S_CRUISE;
            mode_n  = pend_eff;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = S_ZERO;
    endcase

    if (state_n == S_ZERO || state_n == S_IDLE || state_n == S_COOL) mode_n = MODE_ZERO;
    pos_n   = (state_n == S_ZERO) ? POS_CLEAR : (state_n == S_WARP) ? POS_WARP : POS_ACC;
    ready_n = (state_n == S_IDLE) || (state_n == S_CRUISE) || (state_n == S_COOL);
    busy_n  = (state_n == S_ZERO) || (state_n == S_ARM) || (state_n == S_WARP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_ZERO;
      cnt        <= '0;
      pend       <= 4'b0000;
      mode_sel   <= MODE_ZERO;
      pos_sel    <= POS_CLEAR;
      cmd_ready  <= 1'b0;
      busy       <= 1'b1;
      cmd_err    <= 1'b0;
      warp_count <= 8'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pend       <= pend_n;
      mode_sel   <= mode_n;
      pos_sel    <= pos_n;
      cmd_ready  <= ready_n;
      busy       <= busy_n;
      cmd_err    <= err_n;
      warp_count <= wc_n;
    end
  end

endmodule

// File: doc/flight_sequencer.md
Name: flight_sequencer

Overview:
- Command-driven controller for the per-axis position datapath.
- Accepts flight commands over a valid/ready handshake and drives the one-hot velocity-mode select and position select shared by the X/Y/Z axis position units.
- Sequences warp jumps: an arm delay, a single warp load cycle, then an enforced cooldown.
- Reports state, errors and a saturating count of completed warps.

Parameters:
- ARM_CYCLES, 4, cycles spent in WARP_ARM before the warp load; legal range ≥1.
- COOLDOWN_CYCLES, 8, cycles spent in COOLDOWN after a warp; legal range ≥1.
- CNT_W, 4, width of the arm/cooldown down-counter; must hold max(ARM_CYCLES, COOLDOWN_CYCLES)-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_op  in  3  opcodes: 0 NOP, 1 STOP, 2 ATTACK, 3 DEFENSE, 4 STEALTH, 5 WARP, 6 ZERO, 7 reserved.
- cmd_ready  out  1  block can accept a command this cycle.
- mode_sel  out  4  one-hot velocity select: 0001 zero, 0010 attack, 0100 defense, 1000 stealth.
- pos_sel  out  4  one-hot position select: 0001 clear, 0010 accumulate, 0100 warp load; 1000 is never driven.
- busy  out  1  high in ZERO, WARP_ARM, WARP.
- state_o  out  3  0 ZERO, 1 IDLE, 2 CRUISE, 3 WARP_ARM, 4 WARP, 5 COOLDOWN.
- cmd_err  out  1  one-cycle pulse on an illegal accepted command.
- warp_count  out  8  completed warps, saturates at 255.

Behaviour:
- Reset: async on rst_n low. State=ZERO, mode_sel=0001, pos_sel=0001, cmd_ready=0, busy=1, cmd_err=0, warp_count=0, counter=0, pending_mode=none.
- All outputs are registered. A command is accepted when cmd_valid && cmd_ready at a clk edge; select outputs change on that same edge.
- cmd_ready = state in {IDLE, CRUISE, COOLDOWN}.
- Output mapping by state:
  - ZERO: mode 0001, pos 0001.
  - IDLE: mode 0001, pos 0010.
  - CRUISE: mode = current mode, pos 0010.
  - WARP_ARM: mode held from the previous state, pos 0010.
  - WARP: mode held, pos 0100.
  - COOLDOWN: mode 0001, pos 0010.
- ZERO: lasts 1 cycle, then IDLE. Entered on reset release or on accepted ZERO from any ready state.
- IDLE transitions:
  - ATTACK/DEFENSE/STEALTH → CRUISE with that mode.
  - WARP → WARP_ARM, counter loads ARM_CYCLES-1.
  - ZERO → ZERO.
  - NOP/STOP → stay.
- CRUISE transitions:
  - Mode op → stay in CRUISE, new mode from the next cycle.
  - STOP → IDLE.
  - WARP → WARP_ARM.
  - ZERO → ZERO.
- WARP_ARM: counter decrements each cycle; when it is 0, go to WARP. Total time in WARP_ARM is ARM_CYCLES cycles.
- WARP: lasts exactly 1 cycle.
  - warp_count increments unless it is already 255.
  - Next state COOLDOWN, counter loads COOLDOWN_CYCLES-1, pending_mode=none.
- COOLDOWN: lasts COOLDOWN_CYCLES cycles, then goes to CRUISE(pending_mode) if a mode is pending, else IDLE.
  - Mode op: latches pending_mode; the last one wins.
  - STOP: clears pending_mode.
  - WARP: accepted but rejected, cmd_err pulses, no state change.
  - ZERO: goes to ZERO immediately, cooldown cancelled.
- Opcode 7: accepted in any ready state, cmd_err pulses, no state change.
- Simultaneous events: a command accepted on the final COOLDOWN cycle is applied first (pending update or ZERO), and then the exit decision is taken.
- Reset mid-operation (any state): immediate return to reset values; warp_count clears.
- pos_sel and mode_sel are always exactly one-hot.

Optional Feature:
- Macro: FLIGHT_SEQ_WARP_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort high in WARP_ARM → IDLE next edge; no warp, warp_count unchanged, cmd_err pulses.
  - abort is ignored in all other states.
- Undefined: no abort port; WARP_ARM always completes.

Test Plan:
- Reset release → state_o 0 for one cycle with pos_sel=0001, then state_o 1, mode_sel=0001, pos_sel=0010, cmd_ready=1.
- IDLE, ATTACK then DEFENSE on consecutive cycles → mode_sel 0010 then 0100, pos_sel 0010 throughout; STOP → mode_sel 0001.
- CRUISE(STEALTH), WARP with defaults:
  - Expected response: 4 cycles WARP_ARM with mode_sel=1000 and cmd_ready=0, then 1 cycle pos_sel=0100, then 8 cycles COOLDOWN with mode_sel=0001; warp_count=1, then IDLE.
- During COOLDOWN:
  - Stimulus: WARP → cmd_err pulse only; ATTACK then DEFENSE → CRUISE with mode_sel=0100 after cooldown; ZERO in the final cooldown cycle → ZERO state.
- 256 warps back-to-back → warp_count stops at 255; opcode 7 in IDLE → cmd_err=1 for one cycle, state unchanged.
- Assert rst_n low during WARP_ARM (async, mid-cycle) → outputs return to reset values immediately. With FLIGHT_SEQ_WARP_ABORT_EN defined, abort on cycle 2 of arm → IDLE, warp_count unchanged.
